serial_stream_feeder: RTL

Parallel-to-serial feeder that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first, one bit per enabled clock, onto the detector's single-bit `in` line. It flags each valid bit and each completed word. A compile-time option adds a one-word prefetch buffer so consecutive words stream without gaps.

---
 rtl/serial_stream_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/serial_stream_feeder.sv
// serial_stream_feeder
// ---------------------------------------------------------------------------
// Parallel-to-serial feeder for the serial sequence detector. Accepts
// WIDTH-bit words over a valid/ready handshake and presents them MSB-first,
// one bit per shift_en strobe, on serial_out.
//
// Optional feature macro: SERIAL_FEEDER_PREFETCH_EN
//   undefined : single shift register, one bubble cycle between words
//   defined   : adds a one-word hold register so consecutive words stream
//               with no bubble
//
// Ports
//   clk          in   system clock, posedge
//   rst          in   synchronous active-low reset
//   load_valid   in   upstream word present on load_data
//   load_data    in   WIDTH-bit word, bit WIDTH-1 sent first
//   load_ready   out  feeder accepts a word this cycle
//   shift_en     in   consumer advance strobe (0 holds the current bit)
//   serial_out   out  current serial bit (0 whenever serial_valid=0)
//   serial_valid out  serial_out carries a data bit
//   word_done    out  one-cycle pulse after the last bit of a word is consumed
//   busy         out  word in flight or word buffered
//   bit_idx      out  index of the bit currently on serial_out
//   state_dbg    out  FSM state (0=IDLE, 1=SHIFT) for checkers
//
// Handshake: a word transfers on a posedge where load_valid=1 and
// load_ready=1; load_data is ignored otherwise. load_valid may be held
// high across cycles where load_ready=0 without side effects.
// ---------------------------------------------------------------------------
module serial_stream_feeder #(
  parameter int WIDTH = 8,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy,
  output logic [IW-1:0]    bit_idx,
  output logic             state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             word_done_q, word_done_d;
  logic             accept;
  logic             last_bit;

`ifdef SERIAL_FEEDER_PREFETCH_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  assign load_ready = !hold_full_q;
  assign busy       = (state_q == S_SHIFT) || hold_full_q;
`else
  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT);
`endif

  assign accept   = load_valid && load_ready;
  assign last_bit = (state_q == S_SHIFT) && shift_en && (idx_q == '0);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    word_done_d = 1'b0;
`ifdef SERIAL_FEEDER_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sreg_d  = load_data;
          idx_d   = IW'(WIDTH - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
`ifdef SERIAL_FEEDER_PREFETCH_EN
        // A load that coincides with the last bit bypasses hold and goes
        // straight into sreg (handled below); any other load parks in hold.
        if (accept && !last_bit) begin
          hold_d      = load_data;
          hold_full_d = 1'b1;
        end
`endif
        if (shift_en) begin
          if (idx_q != '0) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            idx_d  = idx_q - IW'(1);
          end else begin
            word_done_d = 1'b1;
`ifdef SERIAL_FEEDER_PREFETCH_EN
            if (hold_full_q) begin
              // accept is impossible here: load_ready=0 while hold is full
              sreg_d      = hold_q;
              idx_d       = IW'(WIDTH - 1);
              hold_full_d = 1'b0;
            end else if (accept) begin
              sreg_d = load_data;
              idx_d  = IW'(WIDTH - 1);
            end else begin
              state_d = S_IDLE;
              sreg_d  = '0;
              idx_d   = '0;
            end
`else
            state_d = S_IDLE;
            sreg_d  = '0;
            idx_d   = '0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      idx_q       <= '0;
      word_done_q <= 1'b0;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      idx_q       <= idx_d;
      word_done_q <= word_done_d;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign serial_valid = (state_q == S_SHIFT);
  assign serial_out   = serial_valid && sreg_q[WIDTH-1];
  assign word_done    = word_done_q;
  assign bit_idx      = idx_q;
  assign state_dbg    = state_q;

endmodule
